// File: rtl/wb_arbiter_rr_timeout.sv
// Round-robin Wishbone arbiter sharing one slave port among M_COUNT masters,
// with a watchdog that ends a stalled strobe with a one-cycle error.
module wb_arbiter_rr_timeout #(
    parameter int unsigned M_COUNT      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT      = 16,
    localparam int unsigned CL_M_COUNT  = $clog2(M_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [M_COUNT*ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [M_COUNT*DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [M_COUNT*DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [M_COUNT-1:0]              wbm_we_i,
    input  logic [M_COUNT*SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic [M_COUNT-1:0]              wbm_stb_i,
    output logic [M_COUNT-1:0]              wbm_ack_o,
    output logic [M_COUNT-1:0]              wbm_err_o,
    output logic [M_COUNT-1:0]              wbm_rty_o,
    input  logic [M_COUNT-1:0]              wbm_cyc_i,
    output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
    output logic [DATA_WIDTH-1:0]           wbs_dat_o,
    output logic                            wbs_we_o,
    output logic [SELECT_WIDTH-1:0]         wbs_sel_o,
    output logic                            wbs_stb_o,
    input  logic                            wbs_ack_i,
    input  logic                            wbs_err_i,
    input  logic                            wbs_rty_i,
    output logic                            wbs_cyc_o,
    output logic [M_COUNT-1:0]              grant_o,
    output logic                            timeout_o
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [CL_M_COUNT-1:0] LastReset = CL_M_COUNT'(M_COUNT - 1);
    localparam bit WdEn = (TIMEOUT > 0);

    logic                  r_grant_valid, w_grant_valid_nxt;
    logic [CL_M_COUNT-1:0] r_grant_idx, w_grant_idx_nxt;
    logic [CL_M_COUNT-1:0] r_last_idx, w_last_idx_nxt;
    logic [CntW-1:0]       r_to_cnt, w_to_cnt_nxt;
    logic                  r_to_err, w_to_err_nxt;

    logic                  w_req_found;
    logic [CL_M_COUNT-1:0] w_req_idx;
    logic [CL_M_COUNT-1:0] w_cand;
    logic                  w_term;
    logic                  w_stall;

    // Walk from farthest to nearest so the slot right after last_idx wins.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_cand      = '0;
        for (int k = M_COUNT; k >= 1; k--) begin
            w_cand = CL_M_COUNT'((int'(r_last_idx) + k) % int'(M_COUNT));
            if (wbm_cyc_i[w_cand]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_valid_nxt = r_grant_valid;
        w_grant_idx_nxt   = r_grant_idx;
        w_last_idx_nxt    = r_last_idx;
        if (!r_grant_valid) begin
            if (w_req_found) begin
                w_grant_valid_nxt = 1'b1;
                w_grant_idx_nxt   = w_req_idx;
                w_last_idx_nxt    = w_req_idx;
            end
        end else if (!wbm_cyc_i[r_grant_idx]) begin
            w_grant_valid_nxt = 1'b0;
        end
    end

    assign w_term  = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign w_stall = wbs_stb_o & ~w_term;

    // wbs_stb_o is already masked by to_err, so the counter clears in the error cycle.
    always_comb begin
        w_to_cnt_nxt = '0;
        w_to_err_nxt = 1'b0;
        if (WdEn && w_stall) begin
            w_to_err_nxt = (r_to_cnt == CntLast);
            w_to_cnt_nxt = (r_to_cnt == CntMax) ? r_to_cnt : r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_last_idx    <= LastReset;
            r_to_cnt      <= '0;
            r_to_err      <= 1'b0;
        end else begin
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_last_idx    <= w_last_idx_nxt;
            r_to_cnt      <= w_to_cnt_nxt;
            r_to_err      <= w_to_err_nxt;
        end
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        if (r_grant_valid) begin
            wbs_adr_o = wbm_adr_i[r_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wbs_dat_o = wbm_dat_i[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            wbs_we_o  = wbm_we_i[r_grant_idx];
            wbs_sel_o = wbm_sel_i[r_grant_idx*SELECT_WIDTH +: SELECT_WIDTH];
            wbs_cyc_o = wbm_cyc_i[r_grant_idx] & ~r_to_err;
            wbs_stb_o = wbm_stb_i[r_grant_idx] & ~r_to_err;
        end
    end

    // During the watchdog cycle the slave's own response is dropped.
    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        grant_o   = '0;
        if (r_grant_valid) begin
            wbm_ack_o[r_grant_idx] = wbs_ack_i & ~r_to_err;
            wbm_rty_o[r_grant_idx] = wbs_rty_i & ~r_to_err;
            wbm_err_o[r_grant_idx] = (wbs_err_i & ~r_to_err) | r_to_err;
            grant_o[r_grant_idx]   = 1'b1;
        end
    end

    assign wbm_dat_o = rst ? '0 : {M_COUNT{wbs_dat_i}};
    assign timeout_o = r_to_err;

endmodule

// File: tb/tb_wb_arbiter_rr_timeout.sv
// Bench for wb_arbiter_rr_timeout: TIMEOUT=16 and TIMEOUT=0 instances on shared
// stimulus, checked every cycle against an ownership/stall-count model.
module tb_wb_arbiter_rr_timeout;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] wbm_adr_i, wbm_dat_i;
    logic [3:0]   wbm_we_i, wbm_stb_i, wbm_cyc_i;
    logic [15:0]  wbm_sel_i;
    logic [31:0]  wbs_dat_i;
    logic         wbs_ack_i, wbs_err_i, wbs_rty_i;

    logic [127:0] a_wbm_dat_o, b_wbm_dat_o;
    logic [3:0]   a_wbm_ack_o, a_wbm_err_o, a_wbm_rty_o, a_grant_o;
    logic [3:0]   b_wbm_ack_o, b_wbm_err_o, b_wbm_rty_o, b_grant_o;
    logic [31:0]  a_wbs_adr_o, a_wbs_dat_o, b_wbs_adr_o, b_wbs_dat_o;
    logic [3:0]   a_wbs_sel_o, b_wbs_sel_o;
    logic         a_wbs_we_o, a_wbs_stb_o, a_wbs_cyc_o, a_timeout_o;
    logic         b_wbs_we_o, b_wbs_stb_o, b_wbs_cyc_o, b_timeout_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr_timeout #(.M_COUNT(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(a_wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(a_wbm_ack_o), .wbm_err_o(a_wbm_err_o), .wbm_rty_o(a_wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i), .wbs_adr_o(a_wbs_adr_o), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(a_wbs_dat_o), .wbs_we_o(a_wbs_we_o), .wbs_sel_o(a_wbs_sel_o),
        .wbs_stb_o(a_wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(a_wbs_cyc_o), .grant_o(a_grant_o),
        .timeout_o(a_timeout_o)
    );

    wb_arbiter_rr_timeout #(.M_COUNT(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(b_wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(b_wbm_ack_o), .wbm_err_o(b_wbm_err_o), .wbm_rty_o(b_wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i), .wbs_adr_o(b_wbs_adr_o), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(b_wbs_dat_o), .wbs_we_o(b_wbs_we_o), .wbs_sel_o(b_wbs_sel_o),
        .wbs_stb_o(b_wbs_stb_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i), .wbs_cyc_o(b_wbs_cyc_o), .grant_o(b_grant_o),
        .timeout_o(b_timeout_o)
    );

    // Model: owner (-1 = none), last owner, consecutive stalled strobes, pending watchdog error.
    int m_owner[2] = '{-1, -1};
    int m_last[2]  = '{3, 3};
    int m_stall[2] = '{0, 0};
    bit m_fire[2]  = '{0, 0};
    int tmo[2]     = '{16, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_cycle(input int k, input logic [127:0] dat, input logic [3:0] ack,
                               input logic [3:0] err, input logic [3:0] rty,
                               input logic [31:0] adr, input logic [31:0] sdat, input logic we,
                               input logic [3:0] sel, input logic stb, input logic cyc,
                               input logic [3:0] gnt, input logic to);
        logic [127:0] e_dat;
        logic [3:0]   e_ack, e_err, e_rty, e_gnt, e_sel;
        logic [31:0]  e_adr, e_sdat;
        logic         e_we, e_stb, e_cyc, e_to, term, found;
        logic [215:0] act, exp;
        int g;
        bit f;
        e_dat = '0; e_ack = '0; e_err = '0; e_rty = '0; e_gnt = '0; e_sel = '0;
        e_adr = '0; e_sdat = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0; e_to = 1'b0;
        g = m_owner[k];
        f = m_fire[k];
        if (!rst) begin
            e_dat = {4{wbs_dat_i}};
            e_to  = f;
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_adr    = wbm_adr_i[g*32 +: 32];
                e_sdat   = wbm_dat_i[g*32 +: 32];
                e_we     = wbm_we_i[g];
                e_sel    = wbm_sel_i[g*4 +: 4];
                e_cyc    = wbm_cyc_i[g] && !f;
                e_stb    = wbm_stb_i[g] && !f;
                e_ack[g] = wbs_ack_i && !f;
                e_rty[g] = wbs_rty_i && !f;
                e_err[g] = wbs_err_i || f;
            end
        end
        act = {dat, ack, err, rty, adr, sdat, we, sel, stb, cyc, gnt, to};
        exp = {e_dat, e_ack, e_err, e_rty, e_adr, e_sdat, e_we, e_sel, e_stb, e_cyc, e_gnt, e_to};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle_check inst%0d t=%0t got=%h want=%h", k, $time, act, exp);
        end
        if (rst) begin
            m_owner[k] = -1; m_last[k] = 3; m_stall[k] = 0; m_fire[k] = 1'b0;
        end else begin
            term = wbs_ack_i | wbs_err_i | wbs_rty_i;
            m_stall[k] = (e_stb && !term) ? m_stall[k] + 1 : 0;
            m_fire[k] = 1'b0;
            if (tmo[k] > 0 && m_stall[k] == tmo[k]) begin
                m_fire[k] = 1'b1;
                m_stall[k] = 0;
            end
            if (g < 0) begin
                found = 1'b0;
                for (int j = 1; j <= 4; j++) begin
                    if (!found && wbm_cyc_i[(m_last[k] + j) % 4]) begin
                        found = 1'b1;
                        m_owner[k] = (m_last[k] + j) % 4;
                        m_last[k] = m_owner[k];
                    end
                end
            end else if (!wbm_cyc_i[g]) begin
                m_owner[k] = -1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_cycle(0, a_wbm_dat_o, a_wbm_ack_o, a_wbm_err_o, a_wbm_rty_o, a_wbs_adr_o,
                        a_wbs_dat_o, a_wbs_we_o, a_wbs_sel_o, a_wbs_stb_o, a_wbs_cyc_o,
                        a_grant_o, a_timeout_o);
            model_cycle(1, b_wbm_dat_o, b_wbm_ack_o, b_wbm_err_o, b_wbm_rty_o, b_wbs_adr_o,
                        b_wbs_dat_o, b_wbs_we_o, b_wbs_sel_o, b_wbs_stb_o, b_wbs_cyc_o,
                        b_grant_o, b_timeout_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rem[4];
    int ph[4];
    logic [3:0] seq[8];
    int nseq, gaps, n_to;
    logic [3:0] prev_g;
    bit stall_ep;

    initial begin
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = '0; wbm_sel_i = '0;
        wbm_stb_i = '0; wbm_cyc_i = '0; wbs_dat_i = '0;
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_grant", 32'(a_grant_o), 32'h0);
        chk("reset_cyc", 32'(a_wbs_cyc_o), 32'h0);

        // Single master 2 read
        wbm_cyc_i[2] = 1'b1; wbm_stb_i[2] = 1'b1; wbm_adr_i[64 +: 32] = 32'h100;
        #1;
        chk("idle_grant", 32'(a_grant_o), 32'h0);
        tick(); #1;
        chk("m2_cyc", 32'(a_wbs_cyc_o), 32'h1);
        chk("m2_adr", a_wbs_adr_o, 32'h100);
        chk("m2_grant", 32'(a_grant_o), 32'h4);
        wbs_ack_i = 1'b1; wbs_dat_i = 32'hDEADBEEF;
        #1;
        chk("m2_ack", 32'(a_wbm_ack_o), 32'h4);
        chk("m2_dat", a_wbm_dat_o[64 +: 32], 32'hDEADBEEF);
        tick();
        wbs_ack_i = 1'b0; wbm_cyc_i[2] = 1'b0; wbm_stb_i[2] = 1'b0;
        tick();

        // Round robin over masters 0,1,3 from reset; master 0 asks twice
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rem = '{2, 1, 0, 1};
        ph = '{0, 0, 0, 0};
        wbm_cyc_i = 4'b1011; wbm_stb_i = 4'b1011;
        nseq = 0; gaps = 0; prev_g = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            wbs_ack_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (ph[i] == 2) begin
                    if (rem[i] > 0) begin
                        wbm_cyc_i[i] = 1'b1; wbm_stb_i[i] = 1'b1;
                    end
                    ph[i] = 0;
                end else if (ph[i] == 1) begin
                    wbm_cyc_i[i] = 1'b0; wbm_stb_i[i] = 1'b0; ph[i] = 2;
                end
            end
            #1;
            if (a_grant_o != 4'b0 && prev_g == 4'b0 && nseq < 8) begin
                seq[nseq] = a_grant_o;
                nseq++;
            end else if (a_grant_o == 4'b0 && nseq > 0 && nseq < 4) begin
                gaps++;
            end
            prev_g = a_grant_o;
            if (a_wbs_stb_o) begin
                wbs_ack_i = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (a_grant_o[i] && ph[i] == 0) begin
                        ph[i] = 1; rem[i]--;
                    end
                end
            end
        end
        wbs_ack_i = 1'b0;
        chk("rr_count", 32'(nseq), 32'd4);
        chk("rr_0", 32'(seq[0]), 32'h1);
        chk("rr_1", 32'(seq[1]), 32'h2);
        chk("rr_2", 32'(seq[2]), 32'h8);
        chk("rr_3", 32'(seq[3]), 32'h1);
        chk("rr_gaps", 32'(gaps), 32'd3);

        // No preemption: master 1 bursts, master 0 requests mid-burst
        wbm_cyc_i[1] = 1'b1; wbm_stb_i[1] = 1'b1;
        tick(); #1;
        chk("np_grant1", 32'(a_grant_o), 32'h2);
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                wbm_cyc_i[0] = 1'b1; wbm_stb_i[0] = 1'b1;
            end
            wbs_ack_i = 1'b1;
            #1;
            chk("np_hold", 32'(a_grant_o), 32'h2);
            tick();
        end
        wbs_ack_i = 1'b0; wbm_cyc_i[1] = 1'b0; wbm_stb_i[1] = 1'b0;
        #1;
        chk("np_drop", 32'(a_grant_o), 32'h2);
        tick(); #1;
        chk("np_idle", 32'(a_grant_o), 32'h0);
        tick(); #1;
        chk("np_next", 32'(a_grant_o), 32'h1);

        // Watchdog: master 0 strobes, slave silent, twice
        for (int r = 0; r < 2; r++) begin
            n_to = 0;
            for (int s = 0; s < 16; s++) begin
                if (a_timeout_o || a_wbm_err_o != 4'b0) n_to++;
                tick();
            end
            #1;
            chk("wd_early", 32'(n_to), 32'd0);
            chk("wd_pulse", 32'(a_timeout_o), 32'h1);
            chk("wd_err", 32'(a_wbm_err_o), 32'h1);
            chk("wd_stb", 32'(a_wbs_stb_o), 32'h0);
            tick();
        end

        // Ack on the 16th stalled cycle wins over the watchdog
        n_to = 0;
        for (int s = 0; s < 15; s++) begin
            if (a_timeout_o) n_to++;
            tick();
        end
        wbs_ack_i = 1'b1;
        #1;
        chk("late_ack", 32'(a_wbm_ack_o), 32'h1);
        chk("late_noto", 32'(a_timeout_o) + 32'(n_to), 32'h0);
        tick();
        wbs_ack_i = 1'b0;
        #1;
        chk("late_after", 32'({a_timeout_o, a_wbm_err_o}), 32'h0);

        // TIMEOUT=0 instance never errors on a long stall
        n_to = 0;
        for (int s = 0; s < 100; s++) begin
            if (b_timeout_o || b_wbm_err_o != 4'b0) n_to++;
            tick();
        end
        chk("nowd_stall", 32'(n_to), 32'd0);

        // Reset in the middle of a master 2 transfer
        wbm_cyc_i[0] = 1'b0; wbm_stb_i[0] = 1'b0;
        tick(); tick();
        wbm_cyc_i[2] = 1'b1; wbm_stb_i[2] = 1'b1;
        tick(); #1;
        chk("rst_g2", 32'(a_grant_o), 32'h4);
        tick();
        wbm_cyc_i[0] = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_cyc", 32'(a_wbs_cyc_o), 32'h0);
        chk("rst_gnt", 32'(a_grant_o), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_idle", 32'(a_grant_o), 32'h0);
        tick(); #1;
        chk("rst_m0_first", 32'(a_grant_o), 32'h1);

        // Randomised traffic; alternate epochs starve the slave to reach the watchdog
        for (int n = 0; n < 3000; n++) begin
            tick();
            stall_ep = ((n / 200) % 2) == 1;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, stall_ep ? 63 : 7) == 0) wbm_cyc_i[i] = ~wbm_cyc_i[i];
                wbm_stb_i[i] = wbm_cyc_i[i] & ($urandom_range(0, 3) != 0);
            end
            wbm_adr_i = {$urandom, $urandom, $urandom, $urandom};
            wbm_dat_i = {$urandom, $urandom, $urandom, $urandom};
            wbm_we_i  = 4'($urandom);
            wbm_sel_i = 16'($urandom);
            wbs_dat_i = $urandom;
            wbs_ack_i = !stall_ep && ($urandom_range(0, 3) == 0);
            wbs_err_i = !stall_ep && ($urandom_range(0, 31) == 0);
            wbs_rty_i = !stall_ep && ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 499) == 0);
        end
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr_timeout.md
Name: wb_arbiter_rr_timeout

Overview:
Round-robin Wishbone arbiter that shares one slave port among M_COUNT masters. It adds a bus watchdog that terminates a stalled transfer with an error. It sits between CPU/DMA masters and a shared peripheral interconnect. Master ports are flattened vectors; slot i occupies bits [i*W +: W].

Parameters:
M_COUNT, 4, number of master ports (2..16)
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address bus width
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT, 16, cycles of unterminated strobe before forced error; 0 disables watchdog
CL_M_COUNT, $clog2(M_COUNT), index width (derived)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wbm_adr_i  in  M_COUNT*ADDR_WIDTH  master addresses
wbm_dat_i  in  M_COUNT*DATA_WIDTH  master write data
wbm_dat_o  out  M_COUNT*DATA_WIDTH  read data to masters
wbm_we_i  in  M_COUNT  write enables
wbm_sel_i  in  M_COUNT*SELECT_WIDTH  byte selects
wbm_stb_i  in  M_COUNT  strobes
wbm_ack_o  out  M_COUNT  acks
wbm_err_o  out  M_COUNT  errors
wbm_rty_o  out  M_COUNT  retries
wbm_cyc_i  in  M_COUNT  cycle/request
wbs_adr_o  out  ADDR_WIDTH  slave address
wbs_dat_i  in  DATA_WIDTH  slave read data
wbs_dat_o  out  DATA_WIDTH  slave write data
wbs_we_o  out  1  slave write enable
wbs_sel_o  out  SELECT_WIDTH  slave byte select
wbs_stb_o  out  1  slave strobe
wbs_ack_i  in  1  slave ack
wbs_err_i  in  1  slave error
wbs_rty_i  in  1  slave retry
wbs_cyc_o  out  1  slave cycle
grant_o  out  M_COUNT  one-hot current grant
timeout_o  out  1  one-cycle pulse on watchdog error

Behaviour:
- Registered state: grant_valid, grant_idx, last_idx, to_cnt, to_err. Async reset: grant_valid=0, grant_idx=0, last_idx=M_COUNT-1, to_cnt=0, to_err=0. All outputs 0 during reset.
- IDLE (grant_valid=0): request vector = wbm_cyc_i. Search order is last_idx+1 ... last_idx+M_COUNT (mod M_COUNT); the first set bit wins.
  - On the next edge: grant_idx=winner, last_idx=winner, grant_valid=1.
  - Request at cycle t while IDLE gives slave-side signals at t+1.
- GRANTED: holds while wbm_cyc_i[grant_idx]=1; other requests are ignored and there is no preemption.
  - If wbm_cyc_i[grant_idx]=0, the next edge sets grant_valid=0, giving at least one idle cycle. The earliest next grant is at t+2.
- Slave mux, when granted:
  - wbs_adr_o/dat_o/we_o/sel_o come from slot grant_idx.
  - wbs_cyc_o = wbm_cyc_i[g] & ~to_err.
  - wbs_stb_o = wbm_stb_i[g] & ~to_err.
  - When not granted, all wbs_* outputs are 0.
- Master returns:
  - wbm_dat_o broadcasts wbs_dat_i to every slot.
  - ack/rty go only to the granted slot, gated by ~to_err.
  - err to the granted slot = (wbs_err_i & ~to_err) | to_err.
  - Non-granted slots see ack/err/rty = 0.
- grant_o = grant_valid ? (1<<grant_idx) : 0.
- Watchdog (TIMEOUT>0):
  - to_cnt increments each cycle that wbs_stb_o=1 and none of ack/err/rty is set.
  - to_cnt clears on any termination, on wbs_stb_o=0, or on to_err.
  - When to_cnt==TIMEOUT-1 with stb high and no termination, to_err=1 on the next edge for exactly one cycle. During that cycle: err to master, timeout_o=1, slave cyc/stb forced 0, and any slave ack/err/rty is discarded.
  - to_cnt width is $clog2(TIMEOUT+1). It saturates and never wraps.
- Simultaneous events:
  - Termination in the same cycle to_cnt reaches TIMEOUT-1: the termination wins and no timeout occurs.
  - Master drops cyc in the same cycle the timeout fires: to_err still pulses, the err is delivered, and the grant then releases.
- Reset mid-transfer: grant dropped immediately and asynchronously, outputs 0. After release, arbitration restarts with master 0 as highest priority.
- TIMEOUT=0: to_err is never set and timeout_o stays 0.

Test Plan:
- Single master 2 (cyc/stb, adr=0x100, we=0) → wbs_cyc_o=1 one cycle later, wbs_adr_o=0x100. Slave ack with dat=0xDEADBEEF → wbm_ack_o=4'b0100, slot 2 dat=0xDEADBEEF.
- Masters 0,1,3 all hold cyc after reset, each releasing after one transfer → grant_o sequence 0001, 0010, 1000, 0001, with exactly one wbs_cyc_o=0 cycle between grants.
- Master 1 granted; master 0 asserts cyc mid-burst of 4 transfers → grant_o stays 0010 until master 1 drops cyc, then becomes 0001 two cycles later.
- TIMEOUT=16, slave never acks → after 16 strobe cycles: wbm_err_o[g]=1 and timeout_o=1 for one cycle, wbs_stb_o=0 that cycle. A second stalled transfer repeats the same behaviour.
- Slave acks on the 16th stalled cycle (to_cnt=15) → normal ack, timeout_o stays 0. Also repeat with TIMEOUT=0 and a 100-cycle stall → no err.
- Assert rst while master 2 is mid-transfer → wbs_cyc_o and grant_o go 0 immediately. After rst drops with masters 2 and 0 requesting, master 0 is granted first.
